// File: rtl/crc16_rx_checker_pkg.sv
// crc16_rx_checker_pkg: frame geometry, CRC-16/XMODEM constants, FSM state type and LFSR step.
package crc_pkg;
    localparam int CRC_W   = 16;
    localparam int DATA_W  = 176;
    localparam int FRAME_W = DATA_W + CRC_W;
    localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC16_INIT = 16'h0000;
    typedef enum logic {IDLE, RECV} state_t;
    function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] lfsr, input logic b);
        return {lfsr[CRC_W-2:0], 1'b0} ^ (((b ^ lfsr[CRC_W-1]) != 1'b0) ? CRC16_POLY : '0);
    endfunction
endpackage

// File: rtl/crc16_rx_checker_if.sv
// crc16_rx_checker_if: serial frame input and parallel result bus.
// CRC_RX_STATS_EN adds the good/bad/abort statistics counters.
interface crc16_rx_checker_if;
    import crc_pkg::*;
    logic              in_valid;
    logic              in_sof;
    logic              in_bit;
    logic              busy;
    logic              done;
    logic              crc_ok;
    logic [DATA_W-1:0] data_out;
    logic [7:0]        bit_cnt;
`ifdef CRC_RX_STATS_EN
    logic [15:0]       good_cnt;
    logic [15:0]       bad_cnt;
    logic [15:0]       abort_cnt;
    modport master (output in_valid, in_sof, in_bit,
                    input busy, done, crc_ok, data_out, bit_cnt, good_cnt, bad_cnt, abort_cnt);
    modport slave  (input in_valid, in_sof, in_bit,
                    output busy, done, crc_ok, data_out, bit_cnt, good_cnt, bad_cnt, abort_cnt);
`else
    modport master (output in_valid, in_sof, in_bit,
                    input busy, done, crc_ok, data_out, bit_cnt);
    modport slave  (input in_valid, in_sof, in_bit,
                    output busy, done, crc_ok, data_out, bit_cnt);
`endif
endinterface

// File: rtl/crc16_rx_checker_lfsr.sv
// crc16_lfsr_serial: bit-serial CRC-16 LFSR; load restarts from the seed with bit_in as the first bit.
module crc16_lfsr_serial
    import crc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] lfsr
);
    logic [CRC_W-1:0] lfsr_q, lfsr_d;
    always_comb begin
        lfsr_d = en ? crc16_step(load ? CRC16_INIT : lfsr_q, bit_in) : lfsr_q;
    end
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= CRC16_INIT;
        else     lfsr_q <= lfsr_d;
    end
    assign lfsr = lfsr_q;
endmodule

// File: rtl/crc16_rx_checker.sv
// crc16_rx_checker: receives a 192-bit serial frame MSB first, checks CRC-16 and presents the payload.
// CRC_RX_STATS_EN adds saturating good/bad/abort frame counters.
module crc16_rx_checker
    import crc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    crc16_rx_checker_if.slave rx
);
    localparam logic [7:0] LAST_IDX = 8'(FRAME_W - 1);
    localparam logic [7:0] PAY_BITS = 8'(DATA_W);
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] pay_q, pay_d, data_q, data_d;
    logic              ok_q, ok_d, done_q, done_d;
    logic [CRC_W-1:0]  lfsr;
    logic              recv, sof, take, last;
    assign recv = state_q == RECV;
    assign sof  = rx.in_valid & rx.in_sof;
    assign take = rx.in_valid & recv & ~rx.in_sof;
    assign last = take & (cnt_q == LAST_IDX);
    crc16_lfsr_serial u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (sof),
        .en     (sof | take),
        .bit_in (rx.in_bit),
        .lfsr   (lfsr)
    );
    // The verdict uses the remainder after the last bit, so it is taken from the step value.
    always_comb begin
        state_d = sof ? RECV : (last ? IDLE : state_q);
        cnt_d   = sof ? 8'd1 : (last ? 8'd0 : (take ? cnt_q + 8'd1 : cnt_q));
        pay_d   = (sof | (take & (cnt_q < PAY_BITS))) ? {pay_q[DATA_W-2:0], rx.in_bit} : pay_q;
        done_d  = last;
        data_d  = last ? pay_q : data_q;
        ok_d    = last ? (crc16_step(lfsr, rx.in_bit) == '0) : ok_q;
    end
`ifdef CRC_RX_STATS_EN
    logic [15:0] good_q, good_d, bad_q, bad_d, abort_q, abort_d;
    always_comb begin
        good_d  = good_q + 16'(last & ok_d & ~&good_q);
        bad_d   = bad_q + 16'(last & ~ok_d & ~&bad_q);
        abort_d = abort_q + 16'(sof & recv & ~&abort_q);
    end
    assign rx.good_cnt  = good_q;
    assign rx.bad_cnt   = bad_q;
    assign rx.abort_cnt = abort_q;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pay_q   <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef CRC_RX_STATS_EN
            good_q  <= '0;
            bad_q   <= '0;
            abort_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
            data_q  <= data_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
`ifdef CRC_RX_STATS_EN
            good_q  <= good_d;
            bad_q   <= bad_d;
            abort_q <= abort_d;
`endif
        end
    end
    assign rx.busy     = recv;
    assign rx.done     = done_q;
    assign rx.crc_ok   = ok_q;
    assign rx.data_out = data_q;
    assign rx.bit_cnt  = cnt_q;
endmodule

// File: tb/tb_crc16_rx_checker.sv
// tb_crc16_rx_checker: randomized frames against a polynomial-division model with a done scoreboard.
// Checks the CRC_RX_STATS_EN counters when that macro is defined.
module tb_crc16_rx_checker;
    import crc_pkg::*;
    typedef struct {
        logic              ok;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;
    localparam logic [191:0] GOOD = {176'h313233343536373839, 16'h31C3};
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mdl_good = 0, mdl_bad = 0, mdl_abort = 0;
    bit   in_frame = 1'b0;
    exp_t sb[$];
    crc16_rx_checker_if rx ();
    crc16_rx_checker dut (.clk(clk), .rst(rst), .rx(rx));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [15:0] rem(input logic [191:0] v);
        for (int i = 191; i >= 16; i--) if (v[i]) v[i-:17] = v[i-:17] ^ 17'h11021;
        return v[15:0];
    endfunction
    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [191:0] f, input int nbits, input int gap, input bit push);
        for (int i = 0; i < nbits; i++) begin
            if (i == 0 && in_frame) mdl_abort++;
            in_frame = 1'b1;
            if (i == 191) begin
                in_frame = 1'b0;
                if (push) begin
                    sb.push_back('{ok: rem(f) == 16'h0, data: f[191:16], cyc: cyc + 1});
                    if (rem(f) == 16'h0) mdl_good++;
                    else mdl_bad++;
                end
            end
            rx.in_valid = 1'b1;
            rx.in_sof   = (i == 0);
            rx.in_bit   = f[191-i];
            tick();
            rx.in_valid = 1'b0;
            rx.in_sof   = 1'b0;
            check("bit_cnt", rx.bit_cnt, (i == 191) ? 0 : i + 1);
            check("busy", rx.busy, i != 191);
            if (gap > 0 && (i + 1) % gap == 0 && i != 191)
                repeat (3) begin
                    rx.in_bit = ~rx.in_bit;
                    tick();
                    check("gap_bit_cnt", rx.bit_cnt, i + 1);
                    check("gap_busy", rx.busy, 1'b1);
                end
        end
    endtask
    task automatic check_stats();
`ifdef CRC_RX_STATS_EN
        check("good_cnt", rx.good_cnt, mdl_good);
        check("bad_cnt", rx.bad_cnt, mdl_bad);
        check("abort_cnt", rx.abort_cnt, mdl_abort);
`endif
    endtask
    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, rx.busy, 0);
        check({tag, "_done"}, rx.done, 0);
        check({tag, "_crc_ok"}, rx.crc_ok, 0);
        check({tag, "_data_out"}, rx.data_out, 0);
        check({tag, "_bit_cnt"}, rx.bit_cnt, 0);
    endtask
    always @(negedge clk) begin
        if (rx.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("crc_ok", rx.crc_ok, e.ok);
                check("data_out", rx.data_out, e.data);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end
    initial begin
        logic [191:0] f;
        logic [175:0] p;
        rx.in_valid = 1'b0;
        rx.in_sof   = 1'b0;
        rx.in_bit   = 1'b0;
        repeat (3) tick();
        check_cleared("reset");
        rst = 1'b0;
        tick();
        rx.in_valid = 1'b1;
        rx.in_bit   = 1'b1;
        repeat (4) tick();
        rx.in_valid = 1'b0;
        check("idle_ignore_bit_cnt", rx.bit_cnt, 0);
        check("idle_ignore_busy", rx.busy, 0);
        send(GOOD, 192, 0, 1);
        send('0, 192, 0, 1);
        f = GOOD;
        f[100] = ~f[100];
        send(f, 192, 0, 1);
        f = GOOD;
        f[0] = ~f[0];
        send(f, 192, 0, 1);
        send(GOOD, 192, 10, 1);
        for (int n = 0; n < 8; n++) begin
            p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            f = {p, rem({p, 16'h0})};
            if ($urandom_range(0, 1) == 1) f[$urandom_range(0, 191)] ^= 1'b1;
            send(f, 192, ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 20)) : 0, 1);
        end
        p = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send({p, 16'h1234}, 50, 0, 0);
        send(GOOD, 192, 0, 1);
        tick();
        check_stats();
        send(GOOD, 120, 0, 0);
        rst = 1'b1;
        tick();
        check_cleared("in_rst");
        rst = 1'b0;
        in_frame  = 1'b0;
        mdl_good  = 0;
        mdl_bad   = 0;
        mdl_abort = 0;
        tick();
        check_cleared("after_rst");
        check_stats();
        send(GOOD, 192, 0, 1);
        repeat (5) tick();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_done: got no done expected done at cycle %0d", e.cyc);
        end
        check_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/crc16_rx_checker.md
Name: crc16_rx_checker

Overview:
- Downstream consumer of the 192-bit CRC frame: 176-bit payload followed by a 16-bit CRC.
- Receives the frame bit-serially, MSB first, from the serial link stage.
- Recomputes CRC-16 over all 192 bits and flags the frame good or bad.
- Presents the recovered 176-bit payload in parallel to the next stage.

Parameters:
- DATA_W, 176, payload width in bits.
- CRC_W, 16, CRC width in bits; frame length is DATA_W+CRC_W = 192.
- POLY, 16'h1021, generator polynomial x^16+x^12+x^5+1 (non-reflected).
- INIT, 16'h0000, LFSR seed loaded at start of frame.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  in_bit is valid this cycle.
- in_sof  in  1  qualified by in_valid; marks in_bit as frame bit 191 (first bit).
- in_bit  in  1  serial frame bit, MSB (frame bit 191) first.
- busy  out  1  high while a frame is partially received.
- done  out  1  one-cycle pulse when a frame completes.
- crc_ok  out  1  valid with done; held until the next done.
- data_out  out  DATA_W  recovered payload (frame bits 191:16); held until the next done.
- bit_cnt  out  8  number of bits received in the current frame.

Behaviour:
- Reset: all outputs 0; state IDLE; LFSR = INIT.
- FSM states: IDLE, RECV.
  - IDLE: in_valid & in_sof -> RECV. The LFSR consumes the bit from INIT, bit_cnt = 1, and the bit enters the payload shift register. in_valid without in_sof is ignored.
  - RECV: each in_valid cycle consumes one bit and increments bit_cnt.
    - Bits 1..176 shift into the payload register. Bits 177..192 only go through the LFSR.
  - RECV, 192nd bit accepted: next cycle done=1, crc_ok=(LFSR remainder==0), data_out updated, bit_cnt=0, state -> IDLE.
- Frame check: the full 192-bit frame is divided by POLY. Remainder zero means pass, i.e. frame CRC equals CRC-16/XMODEM of the payload.
- LFSR step per bit b: fb = b ^ lfsr[15]; lfsr = {lfsr[14:0],1'b0} ^ (fb ? POLY : 0).
- in_valid low: state, LFSR and bit_cnt hold. Gaps of any length are allowed.
- in_sof with in_valid while in RECV: the partial frame is discarded with no done pulse. A new frame restarts with this bit as bit 191, exactly as from IDLE.
- Last bit and a new sof in the same cycle: impossible, since sof is itself a bit. A sof on the cycle after the last bit is accepted while done is pulsing.
- busy = (state==RECV).
- data_out/crc_ok change only on done.
- rst mid-frame: frame discarded, no done, all outputs cleared.
- Latency: done asserts 1 cycle after the last bit's in_valid cycle. Minimum frame time is 192 cycles plus 1.

Optional Feature:
- Macro: CRC_RX_STATS_EN.
- Defined: adds outputs good_cnt[15:0], bad_cnt[15:0] and abort_cnt[15:0].
  - All three are saturating counters, cleared by rst.
  - They increment on done&crc_ok, on done&!crc_ok, and on an sof restart in RECV respectively.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package crc_pkg holds:
  - constants CRC_W, DATA_W, FRAME_W, CRC16_POLY, CRC16_INIT;
  - the state typedef {IDLE, RECV};
  - function crc16_step(lfsr, bit).
- One sub-module: crc16_lfsr_serial.
  - Inputs: clk, rst, load, en, bit_in.
  - Output: lfsr[15:0].
  - Shared later with a serial CRC generator.

Test Plan:
- Good frame: payload = 176'h0 with low 72 bits = ASCII "123456789" (0x313233343536373839), CRC = 16'h31C3, sent back-to-back -> done on cycle 193 after the first bit, crc_ok=1, data_out = payload.
- Zero frame: 192 zero bits -> crc_ok=1, data_out=0.
- Corrupt frame: same as the good frame with frame bit 100 flipped -> crc_ok=0, data_out reflects the flipped payload. Also flip CRC bit 0 only -> crc_ok=0.
- Gaps: good frame with in_valid low for 3 cycles after every 10th bit -> crc_ok=1, data_out correct, busy high throughout.
- Restart: sof, 50 bits, then sof and a full good frame -> exactly one done, crc_ok=1. With CRC_RX_STATS_EN: abort_cnt=1, good_cnt=1.
- Reset mid-frame: rst at bit 120, then a full good frame -> no done before the second frame, one done after it with crc_ok=1. Outputs are 0 during and after rst.
